mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//   Shares the single memory bus between the RV32I instruction-fetch port (I) and the load/store port (D).
//   Latches one request, waits for the bus to be free, issues one transaction, and waits for completion or timeout.
//   Then returns read data plus a one-cycle ack to the owning requester.
//   Sits between the CPU control unit / datapath and the memory bus interface.
// PARAMETERS
//   ADDR_W   32   address width
//   DATA_W   32   data width
//   TIMEOUT  255  max cycles spent in ARB_WAIT_ACK before the transaction is aborted with an error
// PORTS
//   clk        in   1       system clock, all logic on posedge
//   rst        in   1       synchronous, active-high reset
//   i_req      in   1       fetch request, level, held until i_ack
//   i_addr     in   ADDR_W  fetch address
//   i_rdata    out  DATA_W  fetched instruction, valid with i_ack, held until next i_ack
//   i_ack      out  1       one-cycle completion pulse for I
//   d_req      in   1       load/store request, level, held until d_ack
//   d_we       in   1       1 = store, 0 = load
//   d_addr     in   ADDR_W  data address
//   d_wdata    in   DATA_W  store data
//   d_be       in   4       byte enables
//   d_rdata    out  DATA_W  load data, valid with d_ack, held until next d_ack
//   d_ack      out  1       one-cycle completion pulse for D
//   bus_full   in   1       bus busy; no issue while high
//   bus_done   in   1       transaction complete; bus_rdata valid this cycle
//   bus_rdata  in   DATA_W  bus read data
//   bus_req    out  1       one-cycle issue pulse
//   bus_we, bus_addr, bus_wdata, bus_be  out  1/ADDR_W/DATA_W/4  latched transaction fields
//   state      out  2       arb_state_t, for debug
//   err        out  1       sticky timeout flag, cleared only by rst
// BEHAVIOUR
//   Reset: state = ARB_IDLE; every output = 0; last_owner = OWN_I; timeout counter = 0.
//   ARB_IDLE: if i_req|d_req, grant per priority rule; latch the winner's addr/we/wdata/be; -> ARB_ISSUE.
//     Fetch always has we=0, be=4'hF.
//   ARB_ISSUE: while bus_full=1, stay. When bus_full=0: bus_req=1 for this cycle; clear counter; -> ARB_WAIT_ACK.
//   ARB_WAIT_ACK: on bus_done, capture bus_rdata (stores capture 0) and go to ARB_RESP.
//     Otherwise the counter increments, saturating.
//     When the counter reaches TIMEOUT: err=1, captured data = 0, -> ARB_RESP.
//     bus_done in the same cycle as expiry: done wins, err is not set.
//   ARB_RESP: pulse owner's ack; update owner's rdata; last_owner = owner; -> ARB_IDLE.
//   bus_we/addr/wdata/be hold latched values from ARB_ISSUE until exit from ARB_WAIT_ACK; otherwise 0.
//   bus_done outside ARB_WAIT_ACK is ignored.
//   Latency: minimum 3 cycles from req to ack (req in c0, bus_req in c1, bus_done in c2, ack in c3).
//   Requests are sampled only in ARB_IDLE.
//     A requester must drop req in the cycle after its ack; a req still high there is a new transaction.
//   rst mid-operation: ARB_IDLE after the edge, no ack emitted, in-flight bus transaction abandoned, err cleared.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN undefined: fixed priority; D wins every tie, so I can starve.
//   ARB_ROUND_ROBIN_EN defined: a tie goes to the port not in last_owner.
//     last_owner resets to OWN_I, so the first tie goes to D.
//   In both modes a lone request is always granted.
// STRUCTURE
//   Package mem_arb_pkg:
//     arb_state_t enum logic[1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_ACK, ARB_RESP}
//     owner_t {OWN_I, OWN_D}
//     localparam BE_ALL = 4'hF
//   Sub-module arb_timeout_ctr: clear, enable, saturating count, expired flag at TIMEOUT.
//   Width is $clog2(TIMEOUT+1).
// TESTING
//   1 Reset: rst=1 for 2 cycles -> state=ARB_IDLE; i_ack=d_ack=bus_req=err=0.
//   2 Fetch: i_addr=0x100; bus_full=0; bus_done one cycle after bus_req with rdata 0x00000013
//     -> bus_req pulse with addr 0x100, we=0, be=F; i_ack on c3 with i_rdata=0x13.
//   3 Tie: i_req and d_req both held, D store 0x2000/0xCAFEF00D/be 4'b0011, four transactions
//     -> fixed priority order D,D,D,D; round-robin order D,I,D,I.
//   4 Busy: bus_full=1 for 5 cycles after request
//     -> bus_req=0 throughout, pulses in the first cycle with bus_full=0.
//   5 Timeout: bus_done never asserted -> ack after TIMEOUT cycles in ARB_WAIT_ACK, rdata=0, err=1 sticky until rst.
//   6 rst asserted in ARB_WAIT_ACK -> no ack, ARB_IDLE the next cycle, err=0, bus fields 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the I/D memory bus arbiter.
// Round-robin tie break is enabled by defining ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_ISSUE    = 2'd1,
    ARB_WAIT_ACK = 2'd2,
    ARB_RESP     = 2'd3
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  localparam logic [3:0] BE_ALL = 4'hF;

  // A lone request always wins; a tie goes to D unless rr_en picks the other port.
  function automatic owner_t arb_grant(
    input logic   i_req,
    input logic   d_req,
    input logic   rr_en,
    input owner_t last
  );
    if (i_req && d_req && rr_en)
      return (last == OWN_I) ? OWN_D : OWN_I;
    return d_req ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/mem_arbiter_timeout.sv
// Saturating wait counter for the arbiter; flags expiry at TIMEOUT.
// No configuration macros.
module arb_timeout_ctr #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] MAX = W'(TIMEOUT);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory bus between instruction fetch (I) and load/store (D).
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed D priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  input  logic              bus_full,
  input  logic              bus_done,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic [3:0]        bus_be,
  output logic [1:0]        state,
  output logic              err
);

`ifdef ARB_ROUND_ROBIN_EN
  localparam logic RR_EN = 1'b1;
`else
  localparam logic RR_EN = 1'b0;
`endif

  arb_state_t        state_q;
  owner_t            owner_q;
  owner_t            last_q;
  owner_t            grant_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] i_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic [DATA_W-1:0] cap_d;
  logic              err_q;
  logic              tmo_clr;
  logic              tmo_en;
  logic              tmo_exp;
  logic              bus_act;

  assign grant_d = arb_grant(i_req, d_req, RR_EN, last_q);
  assign tmo_clr = (state_q == ARB_ISSUE);
  assign tmo_en  = (state_q == ARB_WAIT_ACK) && !bus_done;

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmo_clr),
    .en_i     (tmo_en),
    .expired_o(tmo_exp)
  );

  // Stores and timeouts return zero data.
  always_comb begin
    cap_d = '0;
    if (bus_done && !we_q)
      cap_d = bus_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (i_req || d_req) begin
            owner_q <= grant_d;
            state_q <= ARB_ISSUE;
            if (grant_d == OWN_D) begin
              we_q    <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
              be_q    <= d_be;
            end else begin
              we_q    <= 1'b0;
              addr_q  <= i_addr;
              wdata_q <= '0;
              be_q    <= BE_ALL;
            end
          end
        end
        ARB_ISSUE: begin
          if (!bus_full)
            state_q <= ARB_WAIT_ACK;
        end
        ARB_WAIT_ACK: begin
          if (bus_done || tmo_exp) begin
            if (!bus_done)
              err_q <= 1'b1;
            if (owner_q == OWN_D)
              d_rdata_q <= cap_d;
            else
              i_rdata_q <= cap_d;
            state_q <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          last_q  <= owner_q;
          state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus_act   = (state_q == ARB_ISSUE) || (state_q == ARB_WAIT_ACK);
  assign bus_req   = (state_q == ARB_ISSUE) && !bus_full;
  assign bus_we    = bus_act ? we_q : 1'b0;
  assign bus_addr  = bus_act ? addr_q : '0;
  assign bus_wdata = bus_act ? wdata_q : '0;
  assign bus_be    = bus_act ? be_q : '0;

  assign i_ack   = (state_q == ARB_RESP) && (owner_q == OWN_I);
  assign d_ack   = (state_q == ARB_RESP) && (owner_q == OWN_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized transactions against a transaction-level model.
// Build with ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 255;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [3:0]  d_be = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_full = 1'b0;
  logic        bus_done = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [1:0]  state;
  logic        err;

  int n_run = 0;
  int n_fail = 0;

  logic [31:0] exp_ird = '0;
  logic [31:0] exp_drd = '0;
  bit          exp_err = 1'b0;
  bit          last_d = 1'b0;

  mem_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_ack    (i_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_be     (d_be),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .bus_full (bus_full),
    .bus_done (bus_done),
    .bus_rdata(bus_rdata),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_be   (bus_be),
    .state    (state),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // One full request/response; dly = WAIT_ACK cycle index of bus_done.
  task automatic txn(input bit ir, input bit dr, input bit we,
                     input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] wd, input logic [3:0] be,
                     input int busy, input int dly,
                     input logic [31:0] rd);
    bit          win_d;
    bit          ewe;
    bit          done;
    logic [31:0] ea;
    logic [3:0]  eb;
    logic [31:0] data;
    int          k;
    win_d = dr && !(ir && RR && last_d);
    ewe   = win_d ? we : 1'b0;
    ea    = win_d ? da : ia;
    eb    = win_d ? be : 4'hF;
    done  = 1'b0;
    nx();
    i_req = ir; d_req = dr; d_we = we;
    i_addr = ia; d_addr = da; d_wdata = wd; d_be = be;
    bus_full = 1'($urandom_range(0, 1));
    bus_done = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    chk("idle_state", 32'(state), 32'(ARB_IDLE));
    chk("idle_breq", 32'(bus_req), 0);
    chk("idle_addr", bus_addr, 0);
    for (int b = 0; b < busy; b++) begin
      nx();
      bus_full = 1'b1;
      bus_done = 1'($urandom_range(0, 1));
      #1;
      chk("busy_state", 32'(state), 32'(ARB_ISSUE));
      chk("busy_breq", 32'(bus_req), 0);
      chk("busy_addr", bus_addr, ea);
    end
    nx();
    bus_full = 1'b0;
    bus_done = 1'($urandom_range(0, 1));
    #1;
    chk("issue_breq", 32'(bus_req), 1);
    chk("issue_addr", bus_addr, ea);
    chk("issue_we", 32'(bus_we), 32'(ewe));
    chk("issue_be", 32'(bus_be), 32'(eb));
    if (win_d)
      chk("issue_wdata", bus_wdata, wd);
    k = 0;
    while (k <= TO) begin
      nx();
      bus_full = 1'($urandom_range(0, 1));
      bus_done = (k == dly);
      bus_rdata = rd;
      #1;
      if (k == 0 || bus_done) begin
        chk("wait_state", 32'(state), 32'(ARB_WAIT_ACK));
        chk("wait_breq", 32'(bus_req), 0);
        chk("wait_addr", bus_addr, ea);
      end
      if (bus_done) begin
        done = 1'b1;
        break;
      end
      if (k == TO)
        break;
      k++;
    end
    nx();
    i_req = 1'b0; d_req = 1'b0;
    bus_done = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    #1;
    data = (done && !ewe) ? rd : 32'h0;
    if (!done) exp_err = 1'b1;
    if (win_d) exp_drd = data; else exp_ird = data;
    last_d = win_d;
    chk("resp_iack", 32'(i_ack), 32'(!win_d));
    chk("resp_dack", 32'(d_ack), 32'(win_d));
    chk("resp_irdata", i_rdata, exp_ird);
    chk("resp_drdata", d_rdata, exp_drd);
    chk("resp_err", 32'(err), 32'(exp_err));
    chk("resp_addr", bus_addr, 0);
  endtask

  initial begin
    // Reset held for two cycles
    nx();
    nx();
    #1;
    chk("rst_state", 32'(state), 32'(ARB_IDLE));
    chk("rst_iack", 32'(i_ack), 0);
    chk("rst_dack", 32'(d_ack), 0);
    chk("rst_breq", 32'(bus_req), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_irdata", i_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    chk("rst_baddr", bus_addr, 0);
    rst = 1'b0;

    // Minimum-latency fetch
    txn(1, 0, 0, 32'h100, 32'h0, 32'h0, 4'h0, 0, 0, 32'h00000013);

    // Both ports requesting, four back-to-back grants
    for (int t = 0; t < 4; t++)
      txn(1, 1, 1, 32'h200 + 32'(t * 4), 32'h2000, 32'hCAFEF00D,
          4'b0011, 0, 1, $urandom);

    // Bus busy for five cycles
    txn(0, 1, 0, 32'h0, 32'h3000, 32'h1234, 4'b1100, 5, 2, 32'hA5A5_5A5A);

    for (int t = 0; t < 40; t++) begin
      bit ir;
      bit dr;
      ir = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!ir && !dr) ir = 1'b1;
      txn(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
          4'($urandom_range(0, 15)), $urandom_range(0, 3),
          $urandom_range(0, 5), $urandom);
    end

    // bus_done on the expiry cycle wins over the timeout
    txn(1, 0, 0, 32'h400, 32'h0, 32'h0, 4'h0, 0, TO, 32'h0BAD_F00D);
    // No bus_done at all: timeout, zero data, sticky err
    txn(0, 1, 0, 32'h0, 32'h500, 32'h0, 4'hF, 1, TO + 1, 32'hFFFF_FFFF);
    txn(1, 0, 0, 32'h600, 32'h0, 32'h0, 4'h0, 0, 3, 32'h1111_2222);

    // Reset while waiting on the bus
    nx();
    i_req = 1'b1; d_req = 1'b0; i_addr = 32'h700; bus_full = 1'b0;
    bus_done = 1'b0;
    #1;
    nx();
    #1;
    chk("mid_breq", 32'(bus_req), 1);
    nx();
    i_req = 1'b0;
    #1;
    chk("mid_wait", 32'(state), 32'(ARB_WAIT_ACK));
    nx();
    rst = 1'b1;
    #1;
    nx();
    rst = 1'b0;
    bus_done = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("mid_state", 32'(state), 32'(ARB_IDLE));
    chk("mid_iack", 32'(i_ack), 0);
    chk("mid_dack", 32'(d_ack), 0);
    chk("mid_err", 32'(err), 0);
    chk("mid_addr", bus_addr, 0);
    chk("mid_we", 32'(bus_we), 0);
    chk("mid_be", 32'(bus_be), 0);
    chk("mid_irdata", i_rdata, 0);
    nx();
    bus_done = 1'b0;
    #1;
    chk("mid_idle2", 32'(state), 32'(ARB_IDLE));
    chk("mid_noack", 32'(i_ack), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
